// File: rtl/wb_cmd_pkg.sv
// Shared types and defaults for the single-outstanding Wishbone command master.
package wb_cmd_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_cmd_timeout.sv
// Clear/enable counter that flags the cycle in which the count reaches its limit.
module wb_cmd_timeout #(
    parameter int unsigned limit = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int cnt_w = $clog2(limit + 1);

    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;

    // tc fires in the enabled cycle whose increment would reach the limit.
    assign tc_o = en_i && (cnt_q == cnt_w'(limit - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator fed by a valid/ready command stream.
// Optional ack timeout is built when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int          wb_adr_width   = WB_ADR_W,
    parameter int          wb_dat_width   = WB_DAT_W,
    parameter int unsigned timeout_cycles = WB_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [wb_adr_width-1:0] cmd_adr_i,
    input  logic [wb_dat_width-1:0] cmd_dat_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [wb_dat_width-1:0] rsp_dat_o,
    output logic                    rsp_err_o,
    output logic [wb_adr_width-1:0] wb_adr_o,
    output logic [wb_dat_width-1:0] wb_dat_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    input  logic                    wb_ack_i,
    output logic [1:0]              dbg_state_o
);

    // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
    // valid never waits on ready, and payload stays stable while valid is high.

    wb_state_e state_q;
    wb_state_e state_d;

    logic [wb_adr_width-1:0] adr_q;
    logic [wb_dat_width-1:0] dat_q;
    logic                    we_q;
    logic [wb_dat_width-1:0] rsp_dat_q;
    logic                    timeout_hit;

    assign dbg_state_o = state_q;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic rsp_err_q;

    wb_cmd_timeout #(
        .limit(timeout_cycles)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (state_q != BUS),
        .en_i  ((state_q == BUS) && !wb_ack_i),
        .tc_o  (timeout_hit)
    );

    // Ack has priority, so an abort is flagged only when no ack came with the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == BUS) begin
            if (wb_ack_i) begin
                rsp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (timeout_cycles == 0);
    assign rsp_err_o          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid_i) state_d = BUS;
            BUS:  if (wb_ack_i || timeout_hit) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is gated by rst so it reads low for the whole reset interval.
    always_comb begin
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: cmd_ready_o = rst;
            BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
            end
            RESP: rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            if ((state_q == IDLE) && cmd_valid_i) begin
                adr_q <= cmd_adr_i;
                dat_q <= cmd_dat_i;
                we_q  <= cmd_we_i;
            end
            if (state_q == BUS) begin
                if (wb_ack_i) begin
                    rsp_dat_q <= we_q ? '0 : wb_dat_i;
                end else if (timeout_hit) begin
                    rsp_dat_q <= '0;
                end
            end
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign rsp_dat_o = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master against a small GPIO-style register slave.
module tb_wb_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_cmd_master #(
    .wb_adr_width   (32),
    .wb_dat_width   (32),
    .timeout_cycles (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave: mode 0 = GPIO with registered ack, 1 = never acks, 2 = comb ack in 4th strobe cycle
  int          mode = 0;
  logic        ack_q;
  logic [31:0] gpio_out_q;
  logic [31:0] gpio_dir_q;
  int          stb_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q      <= 1'b0;
      gpio_out_q <= '0;
      gpio_dir_q <= '0;
      stb_cnt    <= 0;
    end else begin
      ack_q   <= (mode == 0) && wb_cyc_o && wb_stb_o && !ack_q;
      stb_cnt <= (wb_cyc_o && wb_stb_o) ? stb_cnt + 1 : 0;
      if ((mode == 0) && wb_cyc_o && wb_stb_o && !ack_q && wb_we_o) begin
        if (wb_adr_o == 32'h4) gpio_out_q <= wb_dat_o;
        if (wb_adr_o == 32'h8) gpio_dir_q <= wb_dat_o;
      end
    end
  end

  always_comb begin
    wb_dat_i = 32'h0;
    if (wb_adr_o == 32'h4) wb_dat_i = gpio_out_q;
    if (wb_adr_o == 32'h8) wb_dat_i = gpio_dir_q;
    wb_ack_i = 1'b0;
    if (mode == 0) wb_ack_i = ack_q;
    if (mode == 2) wb_ack_i = wb_cyc_o && wb_stb_o && (stb_cnt == 3);
  end

  // bus protocol monitor: acks versus cycle starts
  int   ack_cnt = 0;
  int   cyc_starts = 0;
  logic cyc_prev = 1'b0;

  always @(posedge clk) begin
    if (wb_ack_i) ack_cnt++;
    if (wb_cyc_o && !cyc_prev) cyc_starts++;
    cyc_prev = wb_cyc_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // driver: present a command just after a rising edge, return just after the accepting edge
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    bit seen;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_valid_i = 1'b1;
    seen        = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("cmd_accept_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // counts cycles after acceptance until rsp_valid, and cyc-high cycles on the way
  int          lat;
  int          cyc_n;
  logic [31:0] bus_adr_s;
  logic [31:0] bus_dat_s;
  logic        bus_we_s;
  logic        bus_stb_s;

  task automatic wait_rsp();
    lat   = -1;
    cyc_n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_adr_s = wb_adr_o;
        bus_dat_s = wb_dat_o;
        bus_we_s  = wb_we_o;
        bus_stb_s = wb_stb_o;
      end
      if (wb_cyc_o) cyc_n++;
      if (rsp_valid_o) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("rsp_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp();
    @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    rst         = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    rsp_ready_i = 1'b1;

    // reset values
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    check("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("idle_state", {30'd0, dbg_state_o}, 32'd0);
    @(posedge clk);
    #1;

    // write 0xA5 to the output register
    send_cmd(1'b1, 32'h4, 32'hA5);
    wait_rsp();
    check("wr_latency", lat, 32'd3);
    check("wr_cyc_cycles", cyc_n, 32'd2);
    check("wr_bus_we", {31'd0, bus_we_s}, 32'd1);
    check("wr_bus_stb", {31'd0, bus_stb_s}, 32'd1);
    check("wr_bus_adr", bus_adr_s, 32'h4);
    check("wr_bus_dat", bus_dat_s, 32'hA5);
    check("wr_rsp_dat", rsp_dat_o, 32'd0);
    check("wr_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    check("wr_cyc_low_in_resp", {31'd0, wb_cyc_o}, 32'd0);
    finish_rsp();
    check("gpio_out_a5", gpio_out_q, 32'hA5);

    // write dir, then read it back
    send_cmd(1'b1, 32'h8, 32'hFF);
    wait_rsp();
    finish_rsp();
    send_cmd(1'b0, 32'h8, 32'h0);
    wait_rsp();
    check("rd_latency", lat, 32'd3);
    check("rd_cyc_cycles", cyc_n, 32'd2);
    check("rd_bus_we", {31'd0, bus_we_s}, 32'd0);
    check("rd_rsp_dat", rsp_dat_o, 32'h000000FF);
    finish_rsp();

    // backpressure with a queued write behind the read
    rsp_ready_i = 1'b0;
    send_cmd(1'b0, 32'h8, 32'h0);
    wait_rsp();
    check("bp_latency", lat, 32'd3);
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h4;
    cmd_dat_i   = 32'h5A;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp_rsp_dat", rsp_dat_o, 32'hFF);
      check("bp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_dropped", {31'd0, rsp_valid_o}, 32'd0);
    check("bp_ready_after_hs", {31'd0, cmd_ready_o}, 32'd1);
    check("bp_no_early_cyc", {31'd0, wb_cyc_o}, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    wait_rsp();
    check("queued_latency", lat, 32'd3);
    check("queued_rsp_dat", rsp_dat_o, 32'd0);
    finish_rsp();
    check("gpio_out_5a", gpio_out_q, 32'h5A);

    // back-to-back throughput with ready tied high
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h4;
    cmd_dat_i   = 32'h33;
    cmd_valid_i = 1'b1;
    acc         = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_ready_o) acc++;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    check("tput_accepts_12cyc", acc, 32'd3);
    check("gpio_out_33", gpio_out_q, 32'h33);
    check("acks_per_cycle", ack_cnt, cyc_starts);
    check("cyc_starts_gpio", cyc_starts, 32'd8);

    // slave acks in the 4th strobe cycle
    mode = 2;
    send_cmd(1'b0, 32'h8, 32'h0);
    wait_rsp();
    check("late_ack_cyc_cycles", cyc_n, 32'd4);
    check("late_ack_latency", lat, 32'd5);
    check("late_ack_rsp_err", {31'd0, rsp_err_o}, 32'd0);
    check("late_ack_rsp_dat", rsp_dat_o, 32'hFF);
    finish_rsp();
    check("late_ack_count", ack_cnt, 32'd9);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // slave never acks: abort after 4 strobe cycles
    mode = 1;
    send_cmd(1'b0, 32'h4, 32'h0);
    wait_rsp();
    check("to_cyc_cycles", cyc_n, 32'd4);
    check("to_latency", lat, 32'd5);
    check("to_rsp_err", {31'd0, rsp_err_o}, 32'd1);
    check("to_rsp_dat", rsp_dat_o, 32'd0);
    finish_rsp();
`endif

    // async reset while the bus cycle is open
    mode = 1;
    send_cmd(1'b1, 32'h4, 32'h77);
    @(negedge clk);
    @(negedge clk);
    check("mid_cyc_open", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("async_cyc_stb_drop", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("async_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    mode = 0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("post_rst_state", {30'd0, dbg_state_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-outstanding Wishbone classic initiator. Converts a valid/ready command stream (address, data, write enable) into one Wishbone bus cycle, waits for the responder's acknowledge, and returns read data on a valid/ready response stream. Sits between a local controller (the MIDI sequencing logic or a debug port) and the Wishbone peripherals, including the GPIO and other register slaves.

## Interface
- wb_adr_width, 32, Wishbone address width (byte address)
- wb_dat_width, 32, Wishbone data width
- timeout_cycles, 255, cycles to wait for ack before aborting (used only with WB_CMD_MASTER_TIMEOUT_EN); must be ≥ 1

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  master can accept a command
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  wb_adr_width  target address
- cmd_dat_i  in  wb_dat_width  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts response
- rsp_dat_o  out  wb_dat_width  read data; 0 for writes
- rsp_err_o  out  1  cycle aborted by timeout
- wb_adr_o  out  wb_adr_width  bus address
- wb_dat_o  out  wb_dat_width  bus write data
- wb_we_o  out  1  bus write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_dat_i  in  wb_dat_width  bus read data
- wb_ack_i  in  1  bus acknowledge

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1. On cmd_valid_i & cmd_ready_o, register adr/dat/we onto wb_*_o and go to BUS.
- BUS: wb_cyc_o = wb_stb_o = 1, adr/dat/we held stable. cmd_ready_o = 0.
  - On wb_ack_i sampled high: deassert cyc/stb at that same edge, capture wb_dat_i into rsp_dat_o if read (0 if write), rsp_err_o = 0, go to RESP.
  - cyc/stb must be low in the cycle after ack, so a slave with a registered one-cycle ack never sees a second request.
- RESP: rsp_valid_o = 1, rsp_dat_o/rsp_err_o stable until rsp_valid_o & rsp_ready_i, then go to IDLE.
- No pipelining: exactly one transaction in flight. A new command is accepted only in IDLE.
- wb_adr_o/wb_dat_o/wb_we_o retain their last value outside BUS. Only cyc/stb qualify them.
- Async reset mid-cycle: cyc/stb drop immediately and the FSM returns to IDLE. The in-flight command is lost and no response is issued.

## Timing
- Reset values: cmd_ready_o = 0 while reset is asserted, then 1 in IDLE. rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, wb_cyc_o = 0, wb_stb_o = 0, wb_we_o = 0, wb_adr_o = 0, wb_dat_o = 0.
- Cycle sequence:
  - Command accepted at edge N.
  - cyc/stb high from cycle N+1.
  - With a slave acking in cycle N+k, rsp_valid_o is high from cycle N+k+1.
  - Against the GPIO slave (registered ack, k = 2), rsp_valid_o rises 3 cycles after acceptance.
- Throughput against the GPIO slave with rsp_ready_i tied high: one transaction per 4 cycles.
- wb_ack_i is ignored outside BUS.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches timeout_cycles: drop cyc/stb, rsp_dat_o = 0, rsp_err_o = 1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins (normal response, rsp_err_o = 0).
- Not defined: no counter. BUS waits indefinitely for ack. rsp_err_o is tied to 0.

## Structure
- Package wb_cmd_pkg holds:
  - FSM state enum (IDLE/BUS/RESP)
  - default widths WB_ADR_W = 32, WB_DAT_W = 32
  - default timeout constant
- Sub-module wb_cmd_timeout: a clear/enable/terminal-count counter, instantiated only under WB_CMD_MASTER_TIMEOUT_EN.
- Everything else lives in one file.

## Test plan
- Write: cmd we = 1, adr 0x04, dat 0xA5 against the GPIO slave.
  - One cyc/stb pulse of 2 cycles with wb_we_o = 1.
  - rsp_valid_o 3 cycles after accept, rsp_dat_o = 0, rsp_err_o = 0.
  - GPIO output register reads 0xA5.
- Read: write dir = 0xFF at 0x08, then read 0x08.
  - rsp_dat_o = 0x000000FF.
  - Exactly one ack per cyc/stb assertion.
- Backpressure: rsp_ready_i low for 5 cycles after a read.
  - rsp_valid_o and rsp_dat_o held stable.
  - cmd_ready_o stays 0; a queued cmd_valid_i is not accepted until the cycle after the response handshake.
- Timeout (macro on, timeout_cycles = 4): slave never acks.
  - cyc/stb high for 4 cycles, then low.
  - rsp_err_o = 1, rsp_dat_o = 0.
  - Repeat with ack arriving in the 4th cycle: rsp_err_o = 0.
- Reset in BUS: assert rst asynchronously mid-cycle.
  - cyc/stb fall without waiting for a clock edge.
  - No rsp_valid_o after release; cmd_ready_o = 1 on the first edge after release.
